// File: rtl/xbar_nxm.sv
// N-master x M-slave crossbar: per-slave round-robin arbitration, combinational routing,
// and per-slave id FIFOs that steer each in-order read response back to its issuing master.
module xbar_nxm #(
    parameter int N_M     = 2,
    parameter int N_S     = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_M-1:0]        m_req_i,
    input  logic [N_M*ADDR_W-1:0] m_addr_i,
    input  logic [N_M-1:0]        m_cmd_i,
    input  logic [N_M*DATA_W-1:0] m_wdata_i,
    output logic [N_M-1:0]        m_ack_o,
    output logic [N_M*DATA_W-1:0] m_rdata_o,
    output logic [N_M-1:0]        m_resp_o,
    output logic [N_S-1:0]        s_req_o,
    output logic [N_S*ADDR_W-1:0] s_addr_o,
    output logic [N_S-1:0]        s_cmd_o,
    output logic [N_S*DATA_W-1:0] s_wdata_o,
    input  logic [N_S-1:0]        s_ack_i,
    input  logic [N_S*DATA_W-1:0] s_rdata_i,
    input  logic [N_S-1:0]        s_resp_i,
    output logic                  err_o
);
    localparam int SW = $clog2(N_S);
    localparam int MW = $clog2(N_M);
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int PW = $clog2(MAX_OUT);

    // Handshake: a transfer happens in any cycle with req=1 and ack=1; the master holds
    // addr/cmd/wdata stable until then. s_resp_i is a one-cycle strobe with no back-pressure.

    logic [SW-1:0]  tgt    [N_M];
    logic [MW-1:0]  ptr    [N_S];
    logic [MW-1:0]  gnt    [N_S];
    logic [N_S-1:0] gnt_v;
    logic [N_M-1:0] cand   [N_S];
    logic [CW-1:0]  m_cnt  [N_M];
    logic [SW-1:0]  m_last [N_M];
    logic [MW-1:0]  f_mem  [N_S][MAX_OUT];
    logic [PW-1:0]  f_wr   [N_S];
    logic [PW-1:0]  f_rd   [N_S];
    logic [CW-1:0]  f_cnt  [N_S];
    logic [MW-1:0]  head   [N_S];
    logic [N_S-1:0] empty;
    logic [N_S-1:0] pop;
    logic [N_S-1:0] push;
    logic [N_S-1:0] xfer;
    logic [N_M-1:0] resp;
    logic [N_M-1:0] rd_done;

    always_comb begin
        for (int k = 0; k < N_M; k++) begin
            tgt[k] = m_addr_i[k*ADDR_W + ADDR_W - 1 -: SW];
        end
    end

    always_comb begin
        resp      = '0;
        m_rdata_o = '0;
        for (int s = 0; s < N_S; s++) begin
            empty[s] = (f_cnt[s] == '0);
            pop[s]   = s_resp_i[s] && !empty[s] && !rst_i;
            head[s]  = f_mem[s][f_rd[s]];
            if (pop[s]) begin
                resp[head[s]] = 1'b1;
                m_rdata_o[int'(head[s])*DATA_W +: DATA_W] = s_rdata_i[s*DATA_W +: DATA_W];
            end
        end
    end

    assign m_resp_o = resp;

    // A pop in the same cycle frees the slot, so a full count or FIFO does not block the read.
    always_comb begin
        logic ok;
        ok = 1'b0;
        for (int s = 0; s < N_S; s++) begin
            cand[s] = '0;
            for (int k = 0; k < N_M; k++) begin
                ok = (m_cnt[k] == '0) || (m_last[k] == SW'(s));
                if (!m_cmd_i[k]) begin
                    ok = ok && ((m_cnt[k] < CW'(MAX_OUT)) || resp[k])
                            && ((f_cnt[s] < CW'(MAX_OUT)) || pop[s]);
                end
                cand[s][k] = m_req_i[k] && (tgt[k] == SW'(s)) && ok;
            end
        end
    end

    always_comb begin
        int j;
        j = 0;
        for (int s = 0; s < N_S; s++) begin
            gnt_v[s] = 1'b0;
            gnt[s]   = '0;
            for (int i = 0; i < N_M; i++) begin
                j = int'(ptr[s]) + i;
                if (j >= N_M) j = j - N_M;
                if (!gnt_v[s] && cand[s][j]) begin
                    gnt_v[s] = 1'b1;
                    gnt[s]   = MW'(j);
                end
            end
        end
    end

    always_comb begin
        s_req_o   = '0;
        s_addr_o  = '0;
        s_cmd_o   = '0;
        s_wdata_o = '0;
        m_ack_o   = '0;
        xfer      = '0;
        push      = '0;
        for (int s = 0; s < N_S; s++) begin
            s_req_o[s] = gnt_v[s] && !rst_i;
            s_addr_o[s*ADDR_W +: ADDR_W]  = m_addr_i[int'(gnt[s])*ADDR_W +: ADDR_W];
            s_cmd_o[s]                    = m_cmd_i[gnt[s]];
            s_wdata_o[s*DATA_W +: DATA_W] = m_wdata_i[int'(gnt[s])*DATA_W +: DATA_W];
            xfer[s] = s_req_o[s] && s_ack_i[s];
            push[s] = xfer[s] && !m_cmd_i[gnt[s]];
            if (xfer[s]) m_ack_o[gnt[s]] = 1'b1;
        end
        rd_done = m_ack_o & ~m_cmd_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < N_S; s++) begin
                ptr[s]   <= '0;
                f_wr[s]  <= '0;
                f_rd[s]  <= '0;
                f_cnt[s] <= '0;
            end
            for (int k = 0; k < N_M; k++) begin
                m_cnt[k]  <= '0;
                m_last[k] <= '0;
            end
            err_o <= 1'b0;
        end else begin
            for (int s = 0; s < N_S; s++) begin
                if (xfer[s]) ptr[s] <= (int'(gnt[s]) == N_M - 1) ? '0 : gnt[s] + 1'b1;
                if (push[s]) f_wr[s] <= f_wr[s] + 1'b1;
                if (pop[s])  f_rd[s] <= f_rd[s] + 1'b1;
                f_cnt[s] <= f_cnt[s] + CW'(push[s]) - CW'(pop[s]);
            end
            for (int k = 0; k < N_M; k++) begin
                if (rd_done[k]) m_last[k] <= tgt[k];
                m_cnt[k] <= m_cnt[k] + CW'(rd_done[k]) - CW'(resp[k]);
            end
            err_o <= |(s_resp_i & empty);
        end
    end

    always_ff @(posedge clk_i) begin
        for (int s = 0; s < N_S; s++) begin
            if (push[s]) f_mem[s][f_wr[s]] <= gnt[s];
        end
    end
endmodule

// File: tb/tb_xbar_nxm.sv
// Bench for xbar_nxm (2x2): directed scenarios plus random traffic, all checked against
// a queue-based model of arbitration, eligibility and response routing.
module tb_xbar_nxm;
    localparam int NM = 2;
    localparam int NS = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NM-1:0]        m_req, m_cmd, m_ack_o, m_resp_o;
    logic [NM*AW-1:0]     m_addr;
    logic [NM*DW-1:0]     m_wdata, m_rdata_o;
    logic [NS-1:0]        s_req_o, s_cmd_o, s_ack, s_resp;
    logic [NS*AW-1:0]     s_addr_o;
    logic [NS*DW-1:0]     s_wdata_o, s_rdata;
    logic                 err_o;

    xbar_nxm #(.N_M(NM), .N_S(NS), .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)) dut (
        .clk_i(clk), .rst_i(rst),
        .m_req_i(m_req), .m_addr_i(m_addr), .m_cmd_i(m_cmd), .m_wdata_i(m_wdata),
        .m_ack_o(m_ack_o), .m_rdata_o(m_rdata_o), .m_resp_o(m_resp_o),
        .s_req_o(s_req_o), .s_addr_o(s_addr_o), .s_cmd_o(s_cmd_o), .s_wdata_o(s_wdata_o),
        .s_ack_i(s_ack), .s_rdata_i(s_rdata), .s_resp_i(s_resp), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: per-slave queues of master ids, per-master outstanding count.
    int mq [NS][$];
    int cnt [NM];
    int last [NM];
    int ptr [NS];
    int e_gnt [NS];
    logic e_err = 1'b0;
    logic err_nx;
    logic [NM-1:0] e_mack, e_mresp;
    logic [NS-1:0] e_sreq, popv;
    logic [63:0]   e_mrdata;

    function automatic int tgt_of(int k);
        return int'(m_addr[k*AW + AW - 1]);
    endfunction

    function automatic bit eligible(int k, int s);
        if (cnt[k] != 0 && last[k] != s) return 1'b0;
        if (m_cmd[k]) return 1'b1;
        if (cnt[k] >= MO && !e_mresp[k]) return 1'b0;
        if (mq[s].size() >= MO && !popv[s]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_comb();
        e_mresp = '0; e_mrdata = '0; err_nx = 1'b0; popv = '0; e_sreq = '0; e_mack = '0;
        for (int s = 0; s < NS; s++) e_gnt[s] = 0;
        if (rst) return;
        for (int s = 0; s < NS; s++) begin
            if (s_resp[s]) begin
                if (mq[s].size() > 0) begin
                    int m;
                    m = mq[s][0];
                    e_mresp[m] = 1'b1;
                    e_mrdata[m*DW +: DW] = s_rdata[s*DW +: DW];
                    popv[s] = 1'b1;
                end else begin
                    err_nx = 1'b1;
                end
            end
        end
        for (int s = 0; s < NS; s++) begin
            for (int i = 0; i < NM; i++) begin
                int k;
                k = (ptr[s] + i) % NM;
                if (!e_sreq[s] && m_req[k] && tgt_of(k) == s && eligible(k, s)) begin
                    e_sreq[s] = 1'b1;
                    e_gnt[s]  = k;
                    if (s_ack[s]) e_mack[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic model_seq();
        if (rst) begin
            for (int s = 0; s < NS; s++) begin mq[s].delete(); ptr[s] = 0; end
            for (int k = 0; k < NM; k++) begin cnt[k] = 0; last[k] = 0; end
            e_err = 1'b0;
        end else begin
            e_err = err_nx;
            for (int s = 0; s < NS; s++) begin
                if (popv[s]) begin
                    int m;
                    m = mq[s].pop_front();
                    cnt[m]--;
                end
            end
            for (int s = 0; s < NS; s++) begin
                if (e_sreq[s] && s_ack[s]) begin
                    int k;
                    k = e_gnt[s];
                    ptr[s] = (k + 1) % NM;
                    if (!m_cmd[k]) begin
                        mq[s].push_back(k);
                        cnt[k]++;
                        last[k] = s;
                    end
                end
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_comb();
        check_eq("s_req", 64'(s_req_o), 64'(e_sreq));
        check_eq("m_ack", 64'(m_ack_o), 64'(e_mack));
        check_eq("m_resp", 64'(m_resp_o), 64'(e_mresp));
        check_eq("m_rdata", m_rdata_o, e_mrdata);
        check_eq("err", 64'(err_o), 64'(e_err));
        for (int s = 0; s < NS; s++) begin
            if (e_sreq[s]) begin
                check_eq("s_addr", 64'(s_addr_o[s*AW +: AW]), 64'(m_addr[e_gnt[s]*AW +: AW]));
                check_eq("s_wdata", 64'(s_wdata_o[s*DW +: DW]), 64'(m_wdata[e_gnt[s]*DW +: DW]));
                check_eq("s_cmd", 64'(s_cmd_o[s]), 64'(m_cmd[e_gnt[s]]));
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_seq();
        #1;
    endtask

    initial begin
        logic [NM-1:0] pend;
        for (int s = 0; s < NS; s++) ptr[s] = 0;
        for (int k = 0; k < NM; k++) begin cnt[k] = 0; last[k] = 0; end
        rst = 1'b1; m_cmd = '0; m_wdata = '0; s_rdata = '0; s_resp = '0;
        m_req = 2'b11; m_addr = {32'h0000_0010, 32'h0000_0010}; s_ack = 2'b11;

        repeat (2) begin
            sample();
            check_eq("rst_sreq", 64'(s_req_o), 64'd0);
            check_eq("rst_mack", 64'(m_ack_o), 64'd0);
            check_eq("rst_mresp", 64'(m_resp_o), 64'd0);
            check_eq("rst_err", 64'(err_o), 64'd0);
            advance();
        end
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            sample();
            check_eq("fair_ack", 64'(m_ack_o), (i % 2 == 0) ? 64'd1 : 64'd2);
            advance();
        end
        m_req = '0; s_ack = '0;
        for (int i = 0; i < 4; i++) begin
            logic [63:0] want;
            s_resp = 2'b01;
            s_rdata = {32'h0, 32'hA + 32'(i)};
            want = 64'(32'hA + 32'(i)) << (32 * (i % 2));
            sample();
            check_eq("fair_resp", 64'(m_resp_o), (i % 2 == 0) ? 64'd1 : 64'd2);
            check_eq("fair_rdata", m_rdata_o, want);
            advance();
        end
        s_resp = '0;

        m_req = 2'b11; m_cmd = 2'b11; s_ack = 2'b11;
        m_addr = {32'h8000_0000, 32'h0000_0000};
        m_wdata = {32'h2222_2222, 32'h1111_1111};
        sample();
        check_eq("par_ack", 64'(m_ack_o), 64'd3);
        check_eq("par_wdata", 64'(s_wdata_o), {32'h2222_2222, 32'h1111_1111});
        check_eq("par_resp", 64'(m_resp_o), 64'd0);
        advance();
        m_req = '0; m_cmd = '0;

        m_req = 2'b01; m_addr[31:0] = 32'h0000_0000;
        sample(); check_eq("ord_ack0", 64'(m_ack_o), 64'd1); advance();
        m_addr[31:0] = 32'h8000_0004;
        sample(); check_eq("ord_block", 64'(s_req_o), 64'd0); advance();
        s_resp = 2'b01; s_rdata[31:0] = 32'h55;
        sample();
        check_eq("ord_resp", 64'(m_resp_o), 64'd1);
        check_eq("ord_block2", 64'(s_req_o), 64'd0);
        advance();
        s_resp = '0;
        sample();
        check_eq("ord_release", 64'(s_req_o), 64'd2);
        check_eq("ord_ack1", 64'(m_ack_o), 64'd1);
        advance();
        m_req = '0;
        s_resp = 2'b10; s_rdata[63:32] = 32'h66;
        sample(); check_eq("ord_rdata1", m_rdata_o, 64'h66); advance();
        s_resp = '0;

        m_req = 2'b01; m_addr[31:0] = 32'h0000_0020;
        for (int i = 0; i < 4; i++) begin
            sample(); check_eq("full_ack", 64'(m_ack_o), 64'd1); advance();
        end
        sample(); check_eq("full_block", 64'(s_req_o), 64'd0); advance();
        s_resp = 2'b01;
        sample();
        check_eq("full_bypass", 64'(m_ack_o), 64'd1);
        check_eq("full_resp", 64'(m_resp_o), 64'd1);
        advance();
        m_req = '0;
        for (int i = 0; i < 4; i++) begin
            s_resp = 2'b01;
            sample(); check_eq("full_drain", 64'(m_resp_o), 64'd1); advance();
        end
        sample(); check_eq("full_empty", 64'(m_resp_o), 64'd0); advance();
        s_resp = '0;
        sample(); check_eq("full_err", 64'(err_o), 64'd1); advance();

        s_resp = 2'b10;
        sample(); check_eq("err_resp", 64'(m_resp_o), 64'd0); advance();
        s_resp = '0;
        sample(); check_eq("err_pulse", 64'(err_o), 64'd1); advance();
        sample(); check_eq("err_clear", 64'(err_o), 64'd0); advance();

        pend = '0;
        for (int c = 0; c < 3000; c++) begin
            rst = (c >= 1500 && c < 1502);
            for (int k = 0; k < NM; k++) begin
                if (!pend[k] && $urandom_range(0, 1) == 1) begin
                    pend[k] = 1'b1;
                    m_addr[k*AW +: AW]  = $urandom();
                    m_cmd[k]            = 1'($urandom_range(0, 1));
                    m_wdata[k*DW +: DW] = $urandom();
                end
            end
            m_req = pend;
            for (int s = 0; s < NS; s++) begin
                s_ack[s]  = ($urandom_range(0, 9) < 7);
                s_resp[s] = ($urandom_range(0, 9) < 3);
                s_rdata[s*DW +: DW] = $urandom();
            end
            sample();
            pend = pend & ~e_mack;
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
